vga_line_loader: RTL and testbench

Sequences line fills of the dual-clock VGA line FIFO on the pixel clock domain. Detects the VGA controller's per-line load request and latches the requested line number. Issues single-word reads to the frame memory port at frame_base + line*H_PIXELS + x and writes returned bytes into the FIFO write side, with credit-based flow control so the FIFO never overflows. Replaces the bench-only pattern generator between VGA_Controller and vga_fifo.

---
 rtl/vga_line_loader.sv | 182 ++++++++++++++++++
 tb/tb_vga_line_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_loader.sv
// Pixel-clock line fill sequencer: turns VGA line load requests into frame-memory
// reads and pushes the returned bytes into the line FIFO under credit flow control.
module vga_line_loader #(
   parameter int H_PIXELS   = 1280,
   parameter int V_LINES    = 1024,
   parameter int ADDR_W     = 24,
   parameter int LINE_W     = 13,
   parameter int FIFO_DEPTH = 2048,
   parameter int USED_W     = 11,
   parameter int MAX_OUTST  = 8
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iLOAD_REQ,
   input  logic [LINE_W-1:0] iLOAD_LINE,
   input  logic              iFIFO_CLEAR,
   input  logic [ADDR_W-1:0] iFRAME_BASE,
   output logic              oMEM_RD_REQ,
   output logic [ADDR_W-1:0] oMEM_RD_ADDR,
   input  logic              iMEM_RD_ACK,
   input  logic              iMEM_RD_VALID,
   input  logic [7:0]        iMEM_RD_DATA,
   input  logic [USED_W-1:0] iFIFO_WUSEDW,
   output logic [7:0]        oFIFO_WDATA,
   output logic              oFIFO_WREQ,
   output logic              oBUSY,
   output logic              oERR_LATE,
   output logic              oERR_OVF
);
   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int OW = $clog2(MAX_OUTST + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FILL, DRAIN} state_t;

   state_t            state_q, state_d;
   logic              req_q, edge_q;
   logic [LINE_W-1:0] cap_line_q;
   logic              pend_q, pend_d;
   logic [LINE_W-1:0] pend_line_q, pend_line_d;
   logic [ADDR_W-1:0] base_q, base_d, loff_q, loff_d;
   logic [XW-1:0]     xi_q, xi_d, xr_q, xr_d;
   logic [OW-1:0]     outst_q, outst_d;
   logic              wreq_q, wreq_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              late_q, late_d, ovf_q, ovf_d;
   logic [31:0]       lvl_sum;
   logic              space_ok, rd_req, rd_fire, start;
   logic [LINE_W-1:0] start_line;

   // Bytes already in the FIFO plus bytes still owed by memory, plus the
   // two-entry margin for the inverted-clock write path.
   assign lvl_sum  = 32'(iFIFO_WUSEDW) + 32'(outst_q) + 32'd2;
   assign space_ok = lvl_sum <= 32'(FIFO_DEPTH);
   assign rd_req   = (state_q == ISSUE) && (32'(outst_q) < 32'(MAX_OUTST)) && space_ok;
   assign rd_fire  = rd_req && iMEM_RD_ACK;

   assign oMEM_RD_REQ  = rd_req;
   assign oMEM_RD_ADDR = base_q + loff_q + ADDR_W'(xi_q);
   assign oFIFO_WREQ   = wreq_q;
   assign oFIFO_WDATA  = wdata_q;
   assign oBUSY        = (state_q != IDLE);
   assign oERR_LATE    = late_q;
   assign oERR_OVF     = ovf_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         req_q      <= 1'b0;
         edge_q     <= 1'b0;
         cap_line_q <= '0;
      end else begin
         req_q  <= iLOAD_REQ;
         edge_q <= iLOAD_REQ && !req_q;
         if (iLOAD_REQ && !req_q) cap_line_q <= iLOAD_LINE;
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_line_d = pend_line_q;
      base_d      = base_q;
      loff_d      = loff_q;
      xi_d        = xi_q;
      xr_d        = xr_q;
      outst_d     = outst_q;
      wreq_d      = 1'b0;
      wdata_d     = wdata_q;
      late_d      = late_q;
      ovf_d       = ovf_q;
      start       = 1'b0;
      start_line  = cap_line_q;

      if (rd_fire && !iMEM_RD_VALID)                       outst_d = outst_q + OW'(1);
      else if (!rd_fire && iMEM_RD_VALID && outst_q != '0) outst_d = outst_q - OW'(1);
      if (rd_fire) xi_d = xi_q + XW'(1);
      if (iMEM_RD_VALID && state_q != DRAIN) begin
         wreq_d  = 1'b1;
         wdata_d = iMEM_RD_DATA;
         xr_d    = xr_q + XW'(1);
      end

      // A pending line is served before a fresh edge; the fresh one takes the freed slot.
      if (state_q == IDLE) begin
         if (pend_q) begin
            start      = 1'b1;
            start_line = pend_line_q;
            pend_d     = edge_q;
            if (edge_q) pend_line_d = cap_line_q;
         end else if (edge_q) begin
            start = 1'b1;
         end
      end else if (edge_q) begin
         if (pend_q) late_d = 1'b1;
         else begin
            pend_d      = 1'b1;
            pend_line_d = cap_line_q;
         end
      end

      case (state_q)
         IDLE: if (start) begin
            base_d  = iFRAME_BASE;
            loff_d  = ADDR_W'(start_line) * ADDR_W'(H_PIXELS);
            xi_d    = '0;
            xr_d    = '0;
            outst_d = '0;
            state_d = (32'(start_line) >= 32'(V_LINES)) ? FILL : ISSUE;
         end
         ISSUE: if (xi_d == XW'(H_PIXELS)) state_d = WAIT;
         WAIT:  if (xr_q == XW'(H_PIXELS) && outst_q == '0) state_d = IDLE;
         FILL: begin
            if (xi_q == XW'(H_PIXELS)) state_d = IDLE;
            else if (space_ok) begin
               wreq_d  = 1'b1;
               wdata_d = 8'h00;
               xi_d    = xi_q + XW'(1);
            end
         end
         DRAIN: if (outst_q == '0 && !iFIFO_CLEAR) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (iFIFO_CLEAR) begin
         state_d = DRAIN;
         pend_d  = 1'b0;
         wreq_d  = 1'b0;
         wdata_d = wdata_q;
      end

      if (wreq_d && 32'(iFIFO_WUSEDW) >= 32'(FIFO_DEPTH - 1)) ovf_d = 1'b1;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= IDLE;
         pend_q      <= 1'b0;
         pend_line_q <= '0;
         base_q      <= '0;
         loff_q      <= '0;
         xi_q        <= '0;
         xr_q        <= '0;
         outst_q     <= '0;
         wreq_q      <= 1'b0;
         wdata_q     <= '0;
         late_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_line_q <= pend_line_d;
         base_q      <= base_d;
         loff_q      <= loff_d;
         xi_q        <= xi_d;
         xr_q        <= xr_d;
         outst_q     <= outst_d;
         wreq_q      <= wreq_d;
         wdata_q     <= wdata_d;
         late_q      <= late_d;
         ovf_q       <= ovf_d;
      end
   end
endmodule

// File: tb/tb_vga_line_loader.sv
// Bench for vga_line_loader: queue-based memory responder and FIFO level model,
// with each scenario compared against expected line address/byte sequences.
module tb_vga_line_loader;
   localparam int H = 1280, V = 1024, DEPTH = 2048, MAXO = 8;

   logic        iCLK = 0, iRST_N = 0, iLOAD_REQ = 0, iFIFO_CLEAR = 0;
   logic [12:0] iLOAD_LINE = 0;
   logic [23:0] iFRAME_BASE = 0;
   logic        oMEM_RD_REQ;
   logic [23:0] oMEM_RD_ADDR;
   logic        iMEM_RD_ACK = 0, iMEM_RD_VALID = 0;
   logic [7:0]  iMEM_RD_DATA = 0;
   logic [10:0] iFIFO_WUSEDW = 0;
   logic [7:0]  oFIFO_WDATA;
   logic        oFIFO_WREQ, oBUSY, oERR_LATE, oERR_OVF;

   int checks = 0, errors = 0;

   vga_line_loader dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iLOAD_REQ(iLOAD_REQ), .iLOAD_LINE(iLOAD_LINE),
      .iFIFO_CLEAR(iFIFO_CLEAR), .iFRAME_BASE(iFRAME_BASE),
      .oMEM_RD_REQ(oMEM_RD_REQ), .oMEM_RD_ADDR(oMEM_RD_ADDR), .iMEM_RD_ACK(iMEM_RD_ACK),
      .iMEM_RD_VALID(iMEM_RD_VALID), .iMEM_RD_DATA(iMEM_RD_DATA), .iFIFO_WUSEDW(iFIFO_WUSEDW),
      .oFIFO_WDATA(oFIFO_WDATA), .oFIFO_WREQ(oFIFO_WREQ), .oBUSY(oBUSY),
      .oERR_LATE(oERR_LATE), .oERR_OVF(oERR_OVF));

   always #5 iCLK = ~iCLK;

   // Memory responder and FIFO occupancy model, driven on the falling edge.
   typedef struct {int due; logic [7:0] d;} ret_t;
   ret_t        rq[$];
   ret_t        r;
   logic [23:0] acc_q[$], exp_a[$], prev_addr;
   logic [7:0]  wr_q[$], exp_d[$];
   int cyc = 0, lat = 3, ack_pct = 100, ack_budget = -1, lvl = 0;
   int acc_cnt = 0, val_cnt = 0, ob = 0, max_out = 0, rule_viol = 0, both_cnt = 0;
   bit drain_en = 1, prev_pend = 0;

   initial forever begin
      @(negedge iCLK);
      cyc++;
      if (!iRST_N) begin
         rq.delete();
         iMEM_RD_ACK = 0; iMEM_RD_VALID = 0;
         acc_cnt = 0; val_cnt = 0; lvl = 0; iFIFO_WUSEDW = 0; prev_pend = 0;
      end else begin
         if (oFIFO_WREQ) begin wr_q.push_back(oFIFO_WDATA); lvl++; end
         if (drain_en && lvl > 0) lvl--;
         iFIFO_WUSEDW = 11'(lvl);
         ob = acc_cnt - val_cnt;
         if (ob > max_out) max_out = ob;
         iMEM_RD_VALID = 0;
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            iMEM_RD_VALID = 1; iMEM_RD_DATA = rq[0].d;
            void'(rq.pop_front()); val_cnt++;
         end
         iMEM_RD_ACK = 0;
         #1;
         if (prev_pend && !iFIFO_CLEAR && (!oMEM_RD_REQ || oMEM_RD_ADDR !== prev_addr)) rule_viol++;
         prev_pend = 0;
         if (oMEM_RD_REQ) begin
            if (ack_budget != 0 && $urandom_range(99) < ack_pct) begin
               iMEM_RD_ACK = 1;
               if (lvl + ob + 2 > DEPTH || ob >= MAXO) rule_viol++;
               acc_q.push_back(oMEM_RD_ADDR);
               r.due = cyc + lat; r.d = oMEM_RD_ADDR[7:0];
               rq.push_back(r);
               acc_cnt++;
               if (ack_budget > 0) ack_budget--;
               if (iMEM_RD_VALID) both_cnt++;
            end else begin
               prev_pend = 1; prev_addr = oMEM_RD_ADDR;
            end
         end
      end
   end

   // Reference: one line is H byte reads at base+line*H+x (24-bit wrap),
   // memory answers with addr[7:0]; lines at or beyond V become H zero bytes.
   task automatic model_line(input int line, input logic [23:0] base);
      logic [23:0] a;
      for (int x = 0; x < H; x++) begin
         a = base + 24'(line * H) + 24'(x);
         if (line < V) begin exp_a.push_back(a); exp_d.push_back(a[7:0]); end
         else exp_d.push_back(8'h00);
      end
   endtask

   function automatic int diff_a();
      if (acc_q.size() != exp_a.size()) return -2;
      foreach (exp_a[i]) if (acc_q[i] !== exp_a[i]) return i;
      return -1;
   endfunction

   function automatic int diff_d();
      if (wr_q.size() != exp_d.size()) return -2;
      foreach (exp_d[i]) if (wr_q[i] !== exp_d[i]) return i;
      return -1;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin @(negedge iCLK); #3; end
   endtask

   task automatic clr_logs();
      acc_q.delete(); wr_q.delete(); exp_a.delete(); exp_d.delete();
   endtask

   task automatic pulse(input int line, input logic [23:0] base);
      iFRAME_BASE = base; iLOAD_LINE = 13'(line); iLOAD_REQ = 1;
      tick(2);
      iLOAD_REQ = 0;
      tick(1);
   endtask

   task automatic wait_done(input string tag);
      int quiet = 0;
      bit ok = 0;
      for (int c = 0; c < 12000; c++) begin
         tick(1);
         if (!oBUSY && rq.size() == 0 && !oFIFO_WREQ) quiet++; else quiet = 0;
         if (quiet >= 4) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout busy=%0b want idle within 12000 cycles", tag, oBUSY); end
   endtask

   task automatic test_reset();
      iRST_N = 0;
      tick(2);
      checks++;
      if ({oMEM_RD_REQ, oFIFO_WREQ, oBUSY, oERR_LATE, oERR_OVF} !== 5'b0 || oMEM_RD_ADDR !== 24'h0 || oFIFO_WDATA !== 8'h0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b wreq=%b busy=%b late=%b ovf=%b addr=%h wd=%h want all 0",
                  oMEM_RD_REQ, oFIFO_WREQ, oBUSY, oERR_LATE, oERR_OVF, oMEM_RD_ADDR, oFIFO_WDATA);
      end
      iRST_N = 1;
      tick(3);
      checks++;
      if (oBUSY !== 1'b0 || oMEM_RD_REQ !== 1'b0) begin
         errors++; $display("FAIL reset_idle got busy=%b req=%b want 0 0", oBUSY, oMEM_RD_REQ);
      end
   endtask

   task automatic test_main_line();
      bit seen = 0;
      clr_logs(); lat = 3; ack_pct = 100;
      model_line(5, 24'h000100);
      pulse(5, 24'h000100);
      for (int c = 0; c < 5000 && !seen; c++) begin
         if (wr_q.size() >= H) begin
            seen = 1;
            checks++;
            if (oBUSY !== 1'b1) begin errors++; $display("FAIL main_busy_at_last_write got %b want 1", oBUSY); end
         end else tick(1);
      end
      wait_done("main");
      checks++;
      if (acc_q.size() != H || acc_q[0] !== 24'h001A00 || acc_q[H-1] !== 24'h001EFF) begin
         errors++;
         $display("FAIL main_first_last got n=%0d first=%h last=%h want n=%0d 001a00 001eff",
                  acc_q.size(), acc_q.size() > 0 ? acc_q[0] : 24'hx, acc_q.size() >= H ? acc_q[H-1] : 24'hx, H);
      end
      checks++;
      if (diff_a() != -1) begin errors++; $display("FAIL main_addr_seq got diff %0d (n=%0d) want -1", diff_a(), acc_q.size()); end
      checks++;
      if (diff_d() != -1) begin errors++; $display("FAIL main_data_seq got diff %0d (n=%0d) want -1", diff_d(), wr_q.size()); end
      checks++;
      if (oBUSY !== 1'b0) begin errors++; $display("FAIL main_busy_end got %b want 0", oBUSY); end
   endtask

   task automatic test_fifo_level();
      int hold, line;
      logic [23:0] base;
      clr_logs(); lat = 3; ack_pct = 100;
      line = $urandom_range(V - 1); base = 24'($urandom);
      model_line(line, base);
      lvl = 2040; drain_en = 0;
      tick(1);
      pulse(line, base);
      tick(80);
      hold = acc_q.size();
      checks++;
      if (hold < 1 || hold > DEPTH - 2 - 2040 + 1) begin
         errors++; $display("FAIL level_hold_reads got %0d want 1..%0d", hold, DEPTH - 2 - 2040 + 1);
      end
      drain_en = 1;
      wait_done("level");
      checks++;
      if (acc_q.size() <= hold) begin errors++; $display("FAIL level_resume got %0d reads want > %0d", acc_q.size(), hold); end
      checks++;
      if (diff_a() != -1 || diff_d() != -1) begin
         errors++; $display("FAIL level_seq got diff %0d/%0d want -1/-1", diff_a(), diff_d());
      end
      checks++;
      if (rule_viol !== 0 || oERR_OVF !== 1'b0) begin
         errors++; $display("FAIL level_credit got viol=%0d ovf=%b want 0 0", rule_viol, oERR_OVF);
      end
   endtask

   task automatic test_fill();
      clr_logs();
      model_line(1030, 24'h123456);
      pulse(1030, 24'h123456);
      wait_done("fill");
      checks++;
      if (acc_q.size() != 0) begin errors++; $display("FAIL fill_no_reads got %0d want 0", acc_q.size()); end
      checks++;
      if (diff_d() != -1) begin errors++; $display("FAIL fill_zeros got diff %0d (n=%0d) want -1", diff_d(), wr_q.size()); end
   endtask

   task automatic test_clear();
      int line;
      logic [23:0] base;
      bit got5 = 0;
      clr_logs(); lat = 20; ack_pct = 100; ack_budget = 5;
      pulse(7, 24'h00F000);
      for (int c = 0; c < 100 && !got5; c++) if (acc_q.size() >= 5) got5 = 1; else tick(1);
      checks++;
      if (!got5 || acc_q.size() != 5 || wr_q.size() != 0) begin
         errors++; $display("FAIL clear_setup got reads=%0d writes=%0d want 5 0", acc_q.size(), wr_q.size());
      end
      iFIFO_CLEAR = 1; tick(1); iFIFO_CLEAR = 0;
      wait_done("clear");
      checks++;
      if (wr_q.size() != 0 || oBUSY !== 1'b0) begin
         errors++; $display("FAIL clear_discard got writes=%0d busy=%b want 0 0", wr_q.size(), oBUSY);
      end
      ack_budget = -1; lat = 2;
      clr_logs();
      line = $urandom_range(V - 1); base = 24'($urandom);
      model_line(line, base);
      pulse(line, base);
      wait_done("clear_next");
      checks++;
      if (acc_q.size() == 0 || acc_q[0] !== exp_a[0]) begin
         errors++; $display("FAIL clear_restart_x0 got %h want %h", acc_q.size() > 0 ? acc_q[0] : 24'hx, exp_a[0]);
      end
      checks++;
      if (diff_a() != -1 || diff_d() != -1) begin
         errors++; $display("FAIL clear_next_seq got diff %0d/%0d want -1/-1", diff_a(), diff_d());
      end
   endtask

   task automatic test_same_cycle();
      int line;
      logic [23:0] base;
      clr_logs(); lat = 1; ack_pct = 100; max_out = 0; both_cnt = 0;
      line = $urandom_range(V - 1); base = 24'($urandom);
      model_line(line, base);
      pulse(line, base);
      wait_done("same");
      checks++;
      if (both_cnt < 100 || max_out > 1) begin
         errors++; $display("FAIL same_cycle_outst got both=%0d max_out=%0d want >=100 <=1", both_cnt, max_out);
      end
      checks++;
      if (diff_a() != -1 || diff_d() != -1) begin
         errors++; $display("FAIL same_cycle_seq got diff %0d/%0d want -1/-1", diff_a(), diff_d());
      end
   endtask

   task automatic test_random();
      int line;
      logic [23:0] base;
      for (int k = 0; k < 3; k++) begin
         clr_logs();
         lat = $urandom_range(6, 1); ack_pct = $urandom_range(100, 30);
         line = $urandom_range(1100); base = 24'($urandom);
         model_line(line, base);
         pulse(line, base);
         wait_done("rand");
         checks++;
         if (diff_a() != -1 || diff_d() != -1 || rule_viol !== 0) begin
            errors++;
            $display("FAIL rand_line%0d got diff %0d/%0d viol=%0d want -1/-1/0 (line=%0d lat=%0d)",
                     k, diff_a(), diff_d(), rule_viol, line, lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      int la, lb, lc;
      logic [23:0] base;
      clr_logs(); lat = 2; ack_pct = 100;
      la = $urandom_range(V - 1); lb = $urandom_range(V - 1); lc = $urandom_range(V - 1);
      base = 24'($urandom);
      model_line(la, base); model_line(lb, base);
      checks++;
      if (oERR_LATE !== 1'b0) begin errors++; $display("FAIL b2b_late_before got %b want 0", oERR_LATE); end
      pulse(la, base);
      tick(5);
      pulse(lb, base);
      pulse(lc, base);
      wait_done("b2b");
      checks++;
      if (oERR_LATE !== 1'b1) begin errors++; $display("FAIL b2b_late_after got %b want 1", oERR_LATE); end
      checks++;
      if (diff_a() != -1 || diff_d() != -1) begin
         errors++; $display("FAIL b2b_seq got diff %0d/%0d (n=%0d) want -1/-1", diff_a(), diff_d(), wr_q.size());
      end
   endtask

   task automatic test_reset_midline();
      int line;
      logic [23:0] base;
      clr_logs(); lat = 3; ack_pct = 100;
      pulse(200, 24'h000000);
      tick(100);
      iRST_N = 0;
      #1;
      checks++;
      if ({oMEM_RD_REQ, oFIFO_WREQ, oBUSY, oERR_LATE, oERR_OVF} !== 5'b0 || oMEM_RD_ADDR !== 24'h0) begin
         errors++;
         $display("FAIL midline_reset got req=%b wreq=%b busy=%b late=%b ovf=%b addr=%h want all 0",
                  oMEM_RD_REQ, oFIFO_WREQ, oBUSY, oERR_LATE, oERR_OVF, oMEM_RD_ADDR);
      end
      tick(3);
      iRST_N = 1;
      tick(2);
      clr_logs();
      line = $urandom_range(V - 1); base = 24'($urandom);
      model_line(line, base);
      pulse(line, base);
      wait_done("after_reset");
      checks++;
      if (diff_a() != -1 || diff_d() != -1) begin
         errors++; $display("FAIL after_reset_seq got diff %0d/%0d want -1/-1", diff_a(), diff_d());
      end
   endtask

   initial begin
      test_reset();
      test_main_line();
      test_fifo_level();
      test_fill();
      test_clear();
      test_same_cycle();
      test_random();
      test_back_to_back();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got no completion want finish before 900000ns");
      $fatal(1, "watchdog");
   end
endmodule
